hockey_engine: RTL
==================

HOCKEY_ENGINE -- requirements
Module: hockey_engine

Interface
REQ-001 Parameters SHALL be: X_LAST, 4, goal column of player B (field columns 0..X_LAST); Y_ROWS, 5, row count (Y 0..Y_ROWS-1); WIN_SCORE, 3, points to win; STEP_CYC, 3, cycles per puck step; RESP_CYC, 3, response-window cycles; DISP_CYC, 3, display/goal/game-over hold cycles; CW, 3, coordinate width; SW, 2, score width.
REQ-002 Ports SHALL be: clk in 1 clock; rst in 1 reset; BTN_A in 1 player A hit; BTN_B in 1 player B hit; DIR_A in 2 A direction; DIR_B in 2 B direction; Y_in_A in CW A paddle row; Y_in_B in CW B paddle row; X_COORD out CW puck column; Y_COORD out CW puck row; Current_State out 4 FSM state; score_A out SW; score_B out SW; winner out 2 (01=A, 10=B, 00=none).
REQ-003 Design SHALL use one clock; rst SHALL be synchronous and active-low.

Function
REQ-004 DIR encoding SHALL be 00 straight, 01 up (+Y), 10 down (-Y), 11 treated as straight.
REQ-005 States SHALL be IDLE=0, DISPLAY=1, HIT_A=2, HIT_B=3, SEND_A=4, SEND_B=5, RESP_A=6, RESP_B=7, GOAL_A=8, GOAL_B=9, GAME_OVER=10; Current_State SHALL equal the state register with zero lag.
REQ-006 IDLE: BTN_A sets serve=A, else BTN_B sets serve=B, then DISPLAY; simultaneous press SHALL give A priority.
REQ-007 DISPLAY SHALL hold DISP_CYC cycles, then go HIT_A (serve=A) or HIT_B.
REQ-008 HIT_A: BTN_A with Y_in_A<Y_ROWS SHALL load X=0, Y=Y_in_A, dir=DIR_A, go SEND_B; out-of-range Y_in_A SHALL be ignored. HIT_B mirrors with X=X_LAST, go SEND_A.
REQ-009 SEND_B: every STEP_CYC cycles X increments and Y steps per dir; the step reaching X=X_LAST SHALL enter RESP_B. SEND_A mirrors, decrementing to X=0 and entering RESP_A.
REQ-010 Y step: up at Y=Y_ROWS-1 SHALL reverse dir and give Y-1; down at Y=0 SHALL reverse and give Y+1; straight holds Y.
REQ-011 RESP_B: within RESP_CYC cycles, BTN_B with Y_in_B==Y_COORD SHALL set X=X_LAST-1, dir=DIR_B, apply one Y step, go SEND_A; RESP_A mirrors with X=1, DIR_A.
REQ-012 Window expiry in RESP_B SHALL increment score_A and go GOAL_A; in RESP_A increment score_B, go GOAL_B.
REQ-013 GOAL_x SHALL hold DISP_CYC cycles, then GAME_OVER with winner set if score_x==WIN_SCORE, else the conceding player's HIT state.
REQ-014 GAME_OVER SHALL hold DISP_CYC cycles, then IDLE, clearing scores and winner.
REQ-015 Scores SHALL saturate at 2^SW-1; WIN_SCORE SHALL be <= 2^SW-1 (elaboration error otherwise).
REQ-016 Buttons SHALL be ignored in DISPLAY, SEND_x, GOAL_x, GAME_OVER.

Reset
REQ-017 rst low at a clk edge SHALL force IDLE, X=0, Y=0, scores 0, winner 00, dir 00, timer 0, serve A, Current_State 0, including mid-rally.

Configuration
REQ-018 With HOCKEY_SPEEDUP_EN defined, each successful return SHALL decrement the active step period by 1 down to 1, restored to STEP_CYC on every serve; without it the period SHALL stay STEP_CYC.

Structure
REQ-019 Package hockey_pkg SHALL hold the state encoding, DIR encoding and winner codes.
REQ-020 Y bounce logic SHALL be a combinational sub-module hockey_ystep (Y, dir in; next Y, next dir out), instanced once.

Verification
REQ-021 Reset mid-SEND_B -> next cycle Current_State=0, X=0, Y=0, scores 0.
REQ-022 BTN_A+BTN_B in IDLE, then BTN_A in HIT_A with Y_in_A=2, DIR_A=00 -> SEND_B, X 0..4, Y stays 2, RESP_B after 4*STEP_CYC cycles.
REQ-023 Serve Y=3, dir=01, Y_ROWS=5 -> Y sequence 3,4,3,2,1 as X goes 0..4.
REQ-024 RESP_B with Y_in_B==Y_COORD, BTN_B, DIR_B=10 -> X=3, Y-1, SEND_A; wrong row -> score_A=1, GOAL_A, then HIT_B.
REQ-025 Three B misses -> score_A=3, winner=01, GAME_OVER held DISP_CYC cycles, IDLE with scores 0.
REQ-026 HOCKEY_SPEEDUP_EN, STEP_CYC=3, two returns -> steps every 2 then 1 cycle; next serve back to 3.

Source files
------------

// File: rtl/hockey_pkg.sv
// hockey_pkg
// Shared encodings for the air-hockey engine: FSM state numbering (which is
// also what appears on Current_State), puck direction codes, serve side and
// winner codes.
// No ports; imported by hockey_ystep and hockey_engine.

package hockey_pkg;

  // State numbering is externally visible, so every value is pinned.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DISPLAY   = 4'd1,
    ST_HIT_A     = 4'd2,
    ST_HIT_B     = 4'd3,
    ST_SEND_A    = 4'd4,
    ST_SEND_B    = 4'd5,
    ST_RESP_A    = 4'd6,
    ST_RESP_B    = 4'd7,
    ST_GOAL_A    = 4'd8,
    ST_GOAL_B    = 4'd9,
    ST_GAME_OVER = 4'd10
  } state_e;

  // Direction of vertical puck travel; 11 behaves exactly like straight.
  localparam logic [1:0] DIR_STRAIGHT     = 2'b00;
  localparam logic [1:0] DIR_UP           = 2'b01;
  localparam logic [1:0] DIR_DOWN         = 2'b10;
  localparam logic [1:0] DIR_STRAIGHT_ALT = 2'b11;

  typedef enum logic {
    SERVE_A = 1'b0,
    SERVE_B = 1'b1
  } serve_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

endpackage

// File: rtl/hockey_ystep.sv
// hockey_ystep
// Purely combinational vertical step of the puck, including the bounce off
// the top and bottom walls.
// Ports:
//   y_in     in  CW  current puck row
//   dir_in   in  2   direction to apply (00 straight, 01 up, 10 down, 11 straight)
//   y_next   out CW  row after one step
//   dir_next out 2   direction after the step (reversed when a wall was hit)

module hockey_ystep
  import hockey_pkg::*;
#(
  parameter int CW     = 3,
  parameter int Y_ROWS = 5
) (
  input  logic [CW-1:0] y_in,
  input  logic [1:0]    dir_in,
  output logic [CW-1:0] y_next,
  output logic [1:0]    dir_next
);

  localparam logic [CW-1:0] Y_TOP = CW'(Y_ROWS - 1);

  // A move that would leave the field bounces: the direction flips and the
  // puck moves one row back into the field in the same step.
  always_comb begin
    y_next   = y_in;
    dir_next = dir_in;
    case (dir_in)
      DIR_UP: begin
        if (y_in == Y_TOP) begin
          y_next   = y_in - CW'(1);
          dir_next = DIR_DOWN;
        end else begin
          y_next = y_in + CW'(1);
        end
      end
      DIR_DOWN: begin
        if (y_in == '0) begin
          y_next   = y_in + CW'(1);
          dir_next = DIR_UP;
        end else begin
          y_next = y_in - CW'(1);
        end
      end
      default: begin
        y_next   = y_in;
        dir_next = dir_in;
      end
    endcase
  end

endmodule

// File: rtl/hockey_engine.sv
// hockey_engine
// Two-player air-hockey game engine. Player A defends column 0, player B
// defends column X_LAST. The puck travels one column every step period;
// the defender must press its button with its paddle on the puck row while
// the response window is open, otherwise the attacker scores.
// Optional feature macro: HOCKEY_SPEEDUP_EN -- every successful return
// shortens the step period by one cycle (minimum 1), restored on each serve.
// Ports:
//   clk           in  1   clock
//   rst           in  1   synchronous active-low reset
//   BTN_A, BTN_B  in  1   hit buttons of player A / B
//   DIR_A, DIR_B  in  2   direction chosen by player A / B
//   Y_in_A, Y_in_B in CW  paddle row of player A / B
//   X_COORD       out CW  puck column
//   Y_COORD       out CW  puck row
//   Current_State out 4   FSM state (hockey_pkg::state_e numbering)
//   score_A       out SW  points of player A
//   score_B       out SW  points of player B
//   winner        out 2   01 = A, 10 = B, 00 = none

module hockey_engine
  import hockey_pkg::*;
#(
  parameter int X_LAST    = 4,
  parameter int Y_ROWS    = 5,
  parameter int WIN_SCORE = 3,
  parameter int STEP_CYC  = 3,
  parameter int RESP_CYC  = 3,
  parameter int DISP_CYC  = 3,
  parameter int CW        = 3,
  parameter int SW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          BTN_A,
  input  logic          BTN_B,
  input  logic [1:0]    DIR_A,
  input  logic [1:0]    DIR_B,
  input  logic [CW-1:0] Y_in_A,
  input  logic [CW-1:0] Y_in_B,
  output logic [CW-1:0] X_COORD,
  output logic [CW-1:0] Y_COORD,
  output logic [3:0]    Current_State,
  output logic [SW-1:0] score_A,
  output logic [SW-1:0] score_B,
  output logic [1:0]    winner
);

  localparam int MAX_HOLD_AB = (STEP_CYC > RESP_CYC) ? STEP_CYC : RESP_CYC;
  localparam int MAX_HOLD    = (MAX_HOLD_AB > DISP_CYC) ? MAX_HOLD_AB : DISP_CYC;
  localparam int TW          = $clog2(MAX_HOLD + 1);

  localparam logic [TW-1:0] DISP_LAST = TW'(DISP_CYC - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_CYC - 1);
  localparam logic [TW-1:0] STEP_INIT = TW'(STEP_CYC);
  localparam logic [CW-1:0] X_GOAL_B  = CW'(X_LAST);
  localparam logic [CW-1:0] X_RET_B   = CW'(X_LAST - 1);
  localparam logic [SW-1:0] SCORE_MAX = '1;
  localparam logic [SW-1:0] SCORE_WIN = SW'(WIN_SCORE);

  // A winning score that the score counters cannot represent would make
  // the game unwinnable, so refuse to elaborate.
  if (WIN_SCORE > (1 << SW) - 1) begin : g_win_score_check
    $error("hockey_engine: WIN_SCORE does not fit in SW bits");
  end

  state_e        state_q,   state_d;
  logic [CW-1:0] x_q,       x_d;
  logic [CW-1:0] y_q,       y_d;
  logic [1:0]    dir_q,     dir_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [TW-1:0] period_q,  period_d;
  serve_e        serve_q,   serve_d;
  logic [SW-1:0] score_a_q, score_a_d;
  logic [SW-1:0] score_b_q, score_b_d;
  logic [1:0]    winner_q,  winner_d;

  logic [1:0]    ystep_dir_in;
  logic [CW-1:0] ystep_y;
  logic [1:0]    ystep_dir;

  // Period after a successful return: shrinks only when the speed-up
  // feature is built in, otherwise the period is left untouched.
  function automatic logic [TW-1:0] period_after_return(input logic [TW-1:0] p);
`ifdef HOCKEY_SPEEDUP_EN
    return (p > TW'(1)) ? p - TW'(1) : p;
`else
    return p;
`endif
  endfunction

  // On a return the fresh direction from the returning player drives the
  // wall check, not the direction the puck arrived with.
  assign ystep_dir_in = (state_q == ST_RESP_B) ? DIR_B :
                        (state_q == ST_RESP_A) ? DIR_A : dir_q;

  hockey_ystep #(
    .CW     (CW),
    .Y_ROWS (Y_ROWS)
  ) u_ystep (
    .y_in     (y_q),
    .dir_in   (ystep_dir_in),
    .y_next   (ystep_y),
    .dir_next (ystep_dir)
  );

  // Next-state and datapath updates. The single timer is reused by every
  // timed state and is cleared on each transition into one.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    period_d  = period_q;
    serve_d   = serve_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    winner_d  = winner_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (BTN_A) begin
          serve_d = SERVE_A;
          state_d = ST_DISPLAY;
        end else if (BTN_B) begin
          serve_d = SERVE_B;
          state_d = ST_DISPLAY;
        end
      end

      ST_DISPLAY: begin
        if (timer_q == DISP_LAST) begin
          timer_d = '0;
          state_d = (serve_q == SERVE_A) ? ST_HIT_A : ST_HIT_B;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_HIT_A: begin
        if (BTN_A && (int'(Y_in_A) < Y_ROWS)) begin
          x_d      = '0;
          y_d      = Y_in_A;
          dir_d    = DIR_A;
          timer_d  = '0;
          period_d = STEP_INIT;
          state_d  = ST_SEND_B;
        end
      end

      ST_HIT_B: begin
        if (BTN_B && (int'(Y_in_B) < Y_ROWS)) begin
          x_d      = X_GOAL_B;
          y_d      = Y_in_B;
          dir_d    = DIR_B;
          timer_d  = '0;
          period_d = STEP_INIT;
          state_d  = ST_SEND_A;
        end
      end

      ST_SEND_B: begin
        if (timer_q == period_q - TW'(1)) begin
          timer_d = '0;
          x_d     = x_q + CW'(1);
          y_d     = ystep_y;
          dir_d   = ystep_dir;
          if (x_q + CW'(1) == X_GOAL_B) begin
            state_d = ST_RESP_B;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_SEND_A: begin
        if (timer_q == period_q - TW'(1)) begin
          timer_d = '0;
          x_d     = x_q - CW'(1);
          y_d     = ystep_y;
          dir_d   = ystep_dir;
          if (x_q == CW'(1)) begin
            state_d = ST_RESP_A;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // A press on the wrong row does not close the window; only expiry does.
      ST_RESP_B: begin
        if (BTN_B && (Y_in_B == y_q)) begin
          x_d      = X_RET_B;
          y_d      = ystep_y;
          dir_d    = ystep_dir;
          timer_d  = '0;
          period_d = period_after_return(period_q);
          state_d  = ST_SEND_A;
        end else if (timer_q == RESP_LAST) begin
          timer_d   = '0;
          score_a_d = (score_a_q == SCORE_MAX) ? score_a_q : score_a_q + SW'(1);
          state_d   = ST_GOAL_A;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP_A: begin
        if (BTN_A && (Y_in_A == y_q)) begin
          x_d      = CW'(1);
          y_d      = ystep_y;
          dir_d    = ystep_dir;
          timer_d  = '0;
          period_d = period_after_return(period_q);
          state_d  = ST_SEND_B;
        end else if (timer_q == RESP_LAST) begin
          timer_d   = '0;
          score_b_d = (score_b_q == SCORE_MAX) ? score_b_q : score_b_q + SW'(1);
          state_d   = ST_GOAL_B;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // After a goal the conceding player serves next.
      ST_GOAL_A: begin
        if (timer_q == DISP_LAST) begin
          timer_d = '0;
          if (score_a_q == SCORE_WIN) begin
            winner_d = WIN_A;
            state_d  = ST_GAME_OVER;
          end else begin
            state_d = ST_HIT_B;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_GOAL_B: begin
        if (timer_q == DISP_LAST) begin
          timer_d = '0;
          if (score_b_q == SCORE_WIN) begin
            winner_d = WIN_B;
            state_d  = ST_GAME_OVER;
          end else begin
            state_d = ST_HIT_A;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_GAME_OVER: begin
        if (timer_q == DISP_LAST) begin
          timer_d   = '0;
          score_a_d = '0;
          score_b_d = '0;
          winner_d  = WIN_NONE;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= DIR_STRAIGHT;
      timer_q   <= '0;
      period_q  <= STEP_INIT;
      serve_q   <= SERVE_A;
      score_a_q <= '0;
      score_b_q <= '0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      serve_q   <= serve_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      winner_q  <= winner_d;
    end
  end

  assign X_COORD       = x_q;
  assign Y_COORD       = y_q;
  assign Current_State = state_q;
  assign score_A       = score_a_q;
  assign score_B       = score_b_q;
  assign winner        = winner_q;

endmodule
